// File: rtl/csr_enc_hls_deadlock_pkg.sv
// Shared types and default constants for the HLS deadlock watchdog.
// Holds the watchdog FSM encoding and the saturating event-counter helper.
package csr_enc_hls_deadlock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COUNT    = 2'd1,
    ST_DEADLOCK = 2'd2
  } wd_state_e;

  localparam int DEF_NUM_AXIS  = 4;
  localparam int DEF_NUM_INST  = 1;
  localparam int DEF_THRESHOLD = 16;
  localparam int DEF_CNT_W     = 16;

  localparam logic [7:0] EVT_MAX = 8'd255;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    logic [7:0] r;
    if (v == EVT_MAX) begin
      r = v;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/csr_enc_hls_deadlock_persist_cnt.sv
// Persistence counter for the deadlock watchdog: clear, load-one, increment,
// and a terminal flag raised when the count reaches THRESHOLD-1.
module csr_enc_hls_deadlock_persist_cnt #(
  parameter int CNT_W     = 16,
  parameter int THRESHOLD = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clr_i,
  input  logic load_one_i,
  input  logic inc_i,
  output logic term_o
);

  localparam logic [CNT_W-1:0] TERM_VAL = CNT_W'(THRESHOLD - 1);
  localparam logic [CNT_W-1:0] ONE_VAL  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins over load, load wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_one_i) begin
      cnt_d = ONE_VAL;
    end else if (inc_i) begin
      cnt_d = cnt_q + ONE_VAL;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term_o = (cnt_q == TERM_VAL);

endmodule

// File: rtl/csr_enc_hls_deadlock_watchdog.sv
// HLS deadlock watchdog: declares a sticky deadlock once any qualified block
// signal persists for THRESHOLD consecutive cycles; released only by clear.
module csr_enc_hls_deadlock_watchdog
  import csr_enc_hls_deadlock_pkg::*;
#(
  parameter int NUM_AXIS  = DEF_NUM_AXIS,
  parameter int NUM_INST  = DEF_NUM_INST,
  parameter int THRESHOLD = DEF_THRESHOLD,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic [NUM_AXIS-1:0] axis_en,
  input  logic [NUM_INST-1:0] inst_block_sigs,
  input  logic [NUM_INST-1:0] inst_idle_sigs,
  input  logic                clear,
  output logic                block,
  output logic [NUM_AXIS-1:0] block_axis_mask,
  output logic [NUM_INST-1:0] block_inst_mask,
  output logic [7:0]          event_count
);

  localparam bit SINGLE = (THRESHOLD == 1);

  wd_state_e           state_q, state_d;
  logic                block_q, block_d;
  logic [NUM_AXIS-1:0] axis_mask_q, axis_mask_d;
  logic [NUM_INST-1:0] inst_mask_q, inst_mask_d;
  logic [7:0]          event_q, event_d;

  logic [NUM_AXIS-1:0] axis_qual_s;
  logic [NUM_INST-1:0] inst_qual_s;
  logic                any_block_s;
  logic                cnt_clr_s, cnt_load_s, cnt_inc_s, cnt_term_s;
  logic                entry_s;

  // Idle instances cannot be blocked; disabled channels are ignored.
  assign axis_qual_s = axis_block_sigs & axis_en;
  assign inst_qual_s = inst_block_sigs & ~inst_idle_sigs;
  assign any_block_s = (|axis_qual_s) | (|inst_qual_s);

  csr_enc_hls_deadlock_persist_cnt #(
    .CNT_W     (CNT_W),
    .THRESHOLD (THRESHOLD)
  ) u_persist_cnt (
    .clock      (clock),
    .reset      (reset),
    .clr_i      (cnt_clr_s),
    .load_one_i (cnt_load_s),
    .inc_i      (cnt_inc_s),
    .term_o     (cnt_term_s)
  );

  // Next-state, counter control and deadlock-entry detection.
  always_comb begin
    state_d    = state_q;
    cnt_clr_s  = 1'b0;
    cnt_load_s = 1'b0;
    cnt_inc_s  = 1'b0;
    entry_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!any_block_s) begin
          cnt_clr_s = 1'b1;
        end else if (SINGLE) begin
          state_d   = ST_DEADLOCK;
          entry_s   = 1'b1;
          cnt_clr_s = 1'b1;
        end else begin
          state_d    = ST_COUNT;
          cnt_load_s = 1'b1;
        end
      end
      ST_COUNT: begin
        if (!any_block_s) begin
          state_d   = ST_IDLE;
          cnt_clr_s = 1'b1;
        end else if (cnt_term_s) begin
          state_d   = ST_DEADLOCK;
          entry_s   = 1'b1;
          cnt_clr_s = 1'b1;
        end else begin
          cnt_inc_s = 1'b1;
        end
      end
      ST_DEADLOCK: begin
        cnt_clr_s = 1'b1;
        if (!clear) begin
          state_d = ST_DEADLOCK;
        end else if (!any_block_s) begin
          state_d = ST_IDLE;
        end else if (SINGLE) begin
          // Acknowledged but still blocked: this edge is a fresh entry.
          state_d = ST_DEADLOCK;
          entry_s = 1'b1;
        end else begin
          state_d    = ST_COUNT;
          cnt_clr_s  = 1'b0;
          cnt_load_s = 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        cnt_clr_s = 1'b1;
      end
    endcase
  end

  // Output next values: masks capture on entry, hold in DEADLOCK, else zero.
  always_comb begin
    block_d     = (state_d == ST_DEADLOCK);
    axis_mask_d = axis_mask_q;
    inst_mask_d = inst_mask_q;
    event_d     = event_q;
    if (entry_s) begin
      axis_mask_d = axis_qual_s;
      inst_mask_d = inst_qual_s;
      event_d     = sat_inc8(event_q);
    end else if (state_d != ST_DEADLOCK) begin
      axis_mask_d = '0;
      inst_mask_d = '0;
    end else begin
      axis_mask_d = axis_mask_q;
      inst_mask_d = inst_mask_q;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      block_q     <= 1'b0;
      axis_mask_q <= '0;
      inst_mask_q <= '0;
      event_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      block_q     <= block_d;
      axis_mask_q <= axis_mask_d;
      inst_mask_q <= inst_mask_d;
      event_q     <= event_d;
    end
  end

  assign block           = block_q;
  assign block_axis_mask = axis_mask_q;
  assign block_inst_mask = inst_mask_q;
  assign event_count     = event_q;

endmodule

// File: tb/tb_csr_enc_hls_deadlock_watchdog.sv
// Directed scoreboard bench for the deadlock watchdog: one instance at
// THRESHOLD=4 and one at THRESHOLD=1.
module tb_csr_enc_hls_deadlock_watchdog;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       rst4, clr4, blk4;
  logic [3:0] ab4, en4, am4;
  logic [0:0] ib4, ii4, im4;
  logic [7:0] ev4;

  logic       rst1, clr1, blk1;
  logic [3:0] ab1, en1, am1;
  logic [0:0] ib1, ii1, im1;
  logic [7:0] ev1;

  csr_enc_hls_deadlock_watchdog #(
    .NUM_AXIS(4), .NUM_INST(1), .THRESHOLD(4), .CNT_W(16)
  ) u4 (
    .clock(clock), .reset(rst4), .axis_block_sigs(ab4), .axis_en(en4),
    .inst_block_sigs(ib4), .inst_idle_sigs(ii4), .clear(clr4),
    .block(blk4), .block_axis_mask(am4), .block_inst_mask(im4), .event_count(ev4)
  );

  csr_enc_hls_deadlock_watchdog #(
    .NUM_AXIS(4), .NUM_INST(1), .THRESHOLD(1), .CNT_W(16)
  ) u1 (
    .clock(clock), .reset(rst1), .axis_block_sigs(ab1), .axis_en(en1),
    .inst_block_sigs(ib1), .inst_idle_sigs(ii1), .clear(clr1),
    .block(blk1), .block_axis_mask(am1), .block_inst_mask(im1), .event_count(ev1)
  );

  int tests = 0;
  int fails = 0;
  string      tag_q[$];
  logic [13:0] exp_q[$];

  function automatic logic [13:0] pk(input logic b, input logic [3:0] am,
                                     input logic im, input logic [7:0] ev);
    return {b, am, im, ev};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input string t, input logic [13:0] e);
    tag_q.push_back(t);
    exp_q.push_back(e);
  endtask

  task automatic check(input logic [13:0] obs);
    string t;
    logic [13:0] e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL sb_empty observed=%h expected=<none>", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        fails++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  task automatic step4(input string t, input logic [13:0] e);
    push(t, e);
    tick();
    check({blk4, am4, im4, ev4});
  endtask

  task automatic step1(input string t, input logic [13:0] e);
    push(t, e);
    tick();
    check({blk1, am1, im1, ev1});
  endtask

  initial begin
    logic [7:0] ev_exp;
    rst4 = 1'b1; clr4 = 1'b0; ab4 = 4'd0; en4 = 4'hF; ib4 = 1'b0; ii4 = 1'b0;
    rst1 = 1'b1; clr1 = 1'b0; ab1 = 4'd0; en1 = 4'hF; ib1 = 1'b0; ii1 = 1'b0;

    step4("reset4", pk(1'b0, 4'd0, 1'b0, 8'd0));
    push("reset1", pk(1'b0, 4'd0, 1'b0, 8'd0));
    check({blk1, am1, im1, ev1});
    rst4 = 1'b0; rst1 = 1'b0;

    // Four blocked cycles on channel 2 -> deadlock on the fourth edge.
    ab4 = 4'b0100;
    for (int i = 0; i < 3; i++) step4("persist", pk(1'b0, 4'd0, 1'b0, 8'd0));
    step4("enter1", pk(1'b1, 4'b0100, 1'b0, 8'd1));
    step4("sticky", pk(1'b1, 4'b0100, 1'b0, 8'd1));
    clr4 = 1'b1;
    step4("clr_blocked", pk(1'b0, 4'd0, 1'b0, 8'd1));
    clr4 = 1'b0;
    step4("recount2", pk(1'b0, 4'd0, 1'b0, 8'd1));
    step4("recount3", pk(1'b0, 4'd0, 1'b0, 8'd1));
    step4("reenter", pk(1'b1, 4'b0100, 1'b0, 8'd2));
    ab4 = 4'd0;
    step4("sticky_unblk", pk(1'b1, 4'b0100, 1'b0, 8'd2));
    clr4 = 1'b1;
    step4("clr_idle", pk(1'b0, 4'd0, 1'b0, 8'd2));
    step4("clr_in_idle", pk(1'b0, 4'd0, 1'b0, 8'd2));
    clr4 = 1'b0;

    // 3 high, 1 low, 3 high: gap breaks persistence; clear mid-COUNT ignored.
    ab4 = 4'b0100;
    for (int i = 0; i < 3; i++) step4("run_a", pk(1'b0, 4'd0, 1'b0, 8'd2));
    ab4 = 4'd0;
    step4("gap", pk(1'b0, 4'd0, 1'b0, 8'd2));
    ab4 = 4'b0100;
    step4("run_b1", pk(1'b0, 4'd0, 1'b0, 8'd2));
    clr4 = 1'b1;
    step4("clr_in_count", pk(1'b0, 4'd0, 1'b0, 8'd2));
    clr4 = 1'b0;
    step4("run_b3", pk(1'b0, 4'd0, 1'b0, 8'd2));
    step4("run_b4", pk(1'b1, 4'b0100, 1'b0, 8'd3));
    ab4 = 4'd0; clr4 = 1'b1;
    step4("clr3", pk(1'b0, 4'd0, 1'b0, 8'd3));
    clr4 = 1'b0;

    // Instance block path.
    ib4 = 1'b1;
    for (int i = 0; i < 3; i++) step4("inst_run", pk(1'b0, 4'd0, 1'b0, 8'd3));
    step4("inst_enter", pk(1'b1, 4'd0, 1'b1, 8'd4));
    ib4 = 1'b0; clr4 = 1'b1;
    step4("clr4", pk(1'b0, 4'd0, 1'b0, 8'd4));
    clr4 = 1'b0;

    // Masked channel and idle instance never count.
    en4 = 4'b1011; ab4 = 4'b0100;
    for (int i = 0; i < 100; i++) step4("masked_axis", pk(1'b0, 4'd0, 1'b0, 8'd4));
    en4 = 4'hF; ab4 = 4'd0; ib4 = 1'b1; ii4 = 1'b1;
    for (int i = 0; i < 20; i++) step4("idle_inst", pk(1'b0, 4'd0, 1'b0, 8'd4));
    ib4 = 1'b0; ii4 = 1'b0;

    // Enable drop mid-COUNT returns to IDLE immediately.
    ab4 = 4'b0100;
    step4("en_c1", pk(1'b0, 4'd0, 1'b0, 8'd4));
    step4("en_c2", pk(1'b0, 4'd0, 1'b0, 8'd4));
    en4 = 4'b1011;
    step4("en_drop", pk(1'b0, 4'd0, 1'b0, 8'd4));
    en4 = 4'hF;
    for (int i = 0; i < 3; i++) step4("en_recount", pk(1'b0, 4'd0, 1'b0, 8'd4));
    step4("en_enter", pk(1'b1, 4'b0100, 1'b0, 8'd5));
    ab4 = 4'd0; clr4 = 1'b1;
    step4("clr5", pk(1'b0, 4'd0, 1'b0, 8'd5));
    clr4 = 1'b0;

    // Captured mask is the qualified vector and holds while deadlocked.
    en4 = 4'b1011; ab4 = 4'b0110;
    for (int i = 0; i < 3; i++) step4("qual_run", pk(1'b0, 4'd0, 1'b0, 8'd5));
    step4("qual_enter", pk(1'b1, 4'b0010, 1'b0, 8'd6));
    ab4 = 4'hF;
    step4("mask_hold", pk(1'b1, 4'b0010, 1'b0, 8'd6));
    ab4 = 4'd0; clr4 = 1'b1;
    step4("clr6", pk(1'b0, 4'd0, 1'b0, 8'd6));
    clr4 = 1'b0; en4 = 4'hF;

    // Reset mid-COUNT clears the counter; reset mid-DEADLOCK clears outputs.
    ab4 = 4'b0001;
    step4("pre_rst1", pk(1'b0, 4'd0, 1'b0, 8'd6));
    step4("pre_rst2", pk(1'b0, 4'd0, 1'b0, 8'd6));
    rst4 = 1'b1;
    step4("rst_count", pk(1'b0, 4'd0, 1'b0, 8'd0));
    rst4 = 1'b0;
    for (int i = 0; i < 3; i++) step4("post_rst", pk(1'b0, 4'd0, 1'b0, 8'd0));
    step4("post_rst_enter", pk(1'b1, 4'b0001, 1'b0, 8'd1));
    rst4 = 1'b1;
    step4("rst_deadlock", pk(1'b0, 4'd0, 1'b0, 8'd0));
    rst4 = 1'b0; ab4 = 4'd0;

    // Event counter saturation.
    for (int i = 0; i < 300; i++) begin
      ev_exp = (i >= 254) ? 8'd255 : 8'(i + 1);
      ab4 = 4'b0001;
      repeat (3) tick();
      step4("sat_enter", pk(1'b1, 4'b0001, 1'b0, ev_exp));
      ab4 = 4'd0; clr4 = 1'b1;
      step4("sat_clear", pk(1'b0, 4'd0, 1'b0, ev_exp));
      clr4 = 1'b0;
    end

    // THRESHOLD=1: block follows any_block by one edge until latched.
    step1("t1_idle", pk(1'b0, 4'd0, 1'b0, 8'd0));
    ab1 = 4'b0010;
    step1("t1_enter", pk(1'b1, 4'b0010, 1'b0, 8'd1));
    ab1 = 4'd0;
    step1("t1_sticky", pk(1'b1, 4'b0010, 1'b0, 8'd1));
    clr1 = 1'b1;
    step1("t1_clr", pk(1'b0, 4'd0, 1'b0, 8'd1));
    clr1 = 1'b0;
    step1("t1_low", pk(1'b0, 4'd0, 1'b0, 8'd1));
    ab1 = 4'b0001;
    step1("t1_enter2", pk(1'b1, 4'b0001, 1'b0, 8'd2));
    clr1 = 1'b1; ab1 = 4'b1000;
    step1("t1_reenter", pk(1'b1, 4'b1000, 1'b0, 8'd3));
    clr1 = 1'b0; ab1 = 4'd0; rst1 = 1'b1;
    step1("t1_rst_dl", pk(1'b0, 4'd0, 1'b0, 8'd0));
    rst1 = 1'b0; ib1 = 1'b1;
    step1("t1_inst", pk(1'b1, 4'd0, 1'b1, 8'd1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/csr_enc_hls_deadlock_watchdog.md
CSR_ENC_HLS_DEADLOCK_WATCHDOG -- requirements
Module: csr_enc_hls_deadlock_watchdog

Interface
REQ-001 Parameter NUM_AXIS, default 4, sets the number of monitored AXIS channel block signals.
REQ-002 Parameter NUM_INST, default 1, sets the number of monitored sub-instance block/idle pairs.
REQ-003 Parameter THRESHOLD, default 16, range 1..65535, is the consecutive blocked cycles required to declare deadlock.
REQ-004 Parameter CNT_W, default 16, is the persistence counter width; it SHALL satisfy 2**CNT_W > THRESHOLD.
REQ-005 clock  in  1  sole clock, rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 axis_block_sigs  in  NUM_AXIS  per-channel AXIS block indication.
REQ-008 axis_en  in  NUM_AXIS  per-channel monitor enable mask; 0 ignores the channel.
REQ-009 inst_block_sigs  in  NUM_INST  per-instance block indication.
REQ-010 inst_idle_sigs  in  NUM_INST  per-instance idle; idle masks that instance's block.
REQ-011 clear  in  1  single-cycle pulse that acknowledges and releases a declared deadlock.
REQ-012 block  out  1  registered deadlock flag.
REQ-013 block_axis_mask  out  NUM_AXIS  qualified AXIS block vector captured on deadlock entry.
REQ-014 block_inst_mask  out  NUM_INST  qualified instance block vector captured on deadlock entry.
REQ-015 event_count  out  8  number of deadlock entries since reset, saturating.

Function
REQ-016 The design SHALL form any_block = OR(axis_block_sigs & axis_en) | OR(inst_block_sigs & ~inst_idle_sigs), combinationally each cycle.
REQ-017 The FSM SHALL have the states IDLE, COUNT and DEADLOCK.
REQ-018 In IDLE with any_block=1, the FSM SHALL go to DEADLOCK if THRESHOLD=1; otherwise it SHALL go to COUNT with cnt=1.
REQ-019 In IDLE with any_block=0, the FSM SHALL stay in IDLE with cnt=0.
REQ-020 In COUNT, any_block=0 SHALL return the FSM to IDLE and clear cnt to 0; a single unblocked cycle breaks persistence.
REQ-021 In COUNT with any_block=1 and cnt=THRESHOLD-1, the FSM SHALL enter DEADLOCK; otherwise cnt SHALL increment.
REQ-022 block SHALL be 1 exactly while the state is DEADLOCK; with THRESHOLD=N, first block high follows N consecutive any_block cycles by one edge.
REQ-023 THRESHOLD=1 SHALL reproduce single-cycle registered behaviour: block(t+1)=any_block(t) until latched.
REQ-024 On DEADLOCK entry, the block_axis_mask and block_inst_mask SHALL load the qualified vectors of that cycle; the masks SHALL hold while in DEADLOCK.
REQ-025 On DEADLOCK entry, event_count SHALL increment, saturating at 255.
REQ-026 DEADLOCK SHALL be sticky: it SHALL be left only on clear=1.
REQ-027 clear=1 in DEADLOCK with any_block=0 SHALL go to IDLE; with any_block=1 it SHALL go to COUNT with cnt=1, or re-enter DEADLOCK next edge if THRESHOLD=1.
REQ-028 clear in IDLE or COUNT SHALL have no effect.
REQ-029 Masks SHALL clear to 0 when leaving DEADLOCK.
REQ-030 Changes to axis_en SHALL take effect in the same cycle's any_block, including mid-COUNT.

Reset
REQ-031 reset SHALL force state=IDLE, cnt=0, block=0, both masks=0 and event_count=0 on the next rising edge, overriding any state including mid-COUNT and DEADLOCK.
REQ-032 No output SHALL depend combinationally on any input.

Structure
REQ-033 Package csr_enc_hls_deadlock_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-034 The persistence counter (clear, increment, terminal compare) SHALL be the sub-module csr_enc_hls_deadlock_persist_cnt, parametrised by CNT_W and THRESHOLD.

Verification
REQ-035 THRESHOLD=4, axis_en=4'hF, axis_block_sigs[2] high 4 cycles -> block rises 1 cycle after the 4th, block_axis_mask=4'b0100, event_count=1.
REQ-036 THRESHOLD=4, block high 3 cycles, low 1, high 3 -> block never asserts; cnt returns to 0 on the gap.
REQ-037 Hold in DEADLOCK, pulse clear with inputs still blocked -> block drops 1 cycle, reasserts after 4 more blocked cycles, event_count=2.
REQ-038 axis_en=4'b1011, axis_block_sigs[2]=1 for 100 cycles -> block stays 0; inst_block_sigs[0]=1 with inst_idle_sigs[0]=1 -> block stays 0.
REQ-039 THRESHOLD=1 -> block follows any_block delayed 1 cycle; reset asserted mid-DEADLOCK -> all outputs 0 next edge.
REQ-040 Force 300 deadlock/clear cycles -> event_count saturates at 255 and stays there.
